// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: two half-adder passes per bit, one bit per clock,
// with valid/ready handshakes on operand intake and result delivery.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic w_s1;
  logic w_c1;
  logic w_s2;
  logic w_c2;

  half_adder u_ha1 (
    .i_a (r_sa[0]),
    .i_b (r_sb[0]),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  half_adder u_ha2 (
    .i_a (w_s1),
    .i_b (r_c),
    .o_s (w_s2),
    .o_c (w_c2)
  );

  // Handshake and busy flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_res       <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sa       <= a;
            r_sb       <= b;
            r_c        <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_res <= {w_s2, r_res[WIDTH-1:1]};
          r_c   <= w_c1 | w_c2;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          if (r_cnt == LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_res;
  assign cout      = r_c;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed corner cases plus random
// operands checked against plain integer addition.
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int busy_cnt = 0;
  int stalls = 0;
  bit ov_prev = 1'b0;
  bit rand_or = 1'b0;
  logic [W:0] q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      ov_prev  = 1'b0;
      busy_cnt = 0;
      stalls   = 0;
    end else begin
      if (busy) busy_cnt++;
      if (out_valid && !ov_prev) check("latency", cyc - acc_cyc, W);
      if (out_valid && !out_ready) stalls++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("sum_cout", {cout, sum}, q.pop_front());
          check("busy_cycles", busy_cnt, W + 1 + stalls);
        end
        busy_cnt = 0;
        stalls   = 0;
      end
      ov_prev = out_valid;
    end
  end

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input bit keep, input bit gap);
    int  n = 0;
    bit  ok = 1'b0;
    int  new_acc;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready && rst_n) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
    end else begin
      q.push_back({1'b0, ia} + {1'b0, ib});
      new_acc = cyc + 1;
      if (gap) check("accept_gap", new_acc - acc_cyc, W + 2);
      acc_cyc  = new_acc;
      busy_cnt = 0;
    end
    tick();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    tick();

    do_op(8'h00, 8'h00, 0, 0);
    drain();
    do_op(8'hFF, 8'h01, 0, 0);
    drain();
    do_op(8'hA5, 8'h5A, 0, 0);
    drain();
    do_op(8'hC8, 8'h64, 0, 0);
    drain();

    // Backpressure: result must hold while out_ready stays low.
    out_ready = 1'b0;
    do_op(8'h3C, 8'h4B, 0, 0);
    for (int n = 0; n < 50 && !out_valid; n++) begin
      @(negedge clk);
      if (!out_valid) tick();
    end
    check("bp_reached_done", out_valid, 1);
    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_result", {cout, sum}, 9'h087);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) tick();
    @(negedge clk);
    check("bp_no_extra", out_valid | busy, 0);
    tick();

    // Reset on the 4th RUN cycle discards the operation.
    do_op(8'hFF, 8'hFF, 0, 0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    rst_n = 1'b1;
    tick();
    do_op(8'h0F, 8'h01, 0, 0);
    drain();

    // Back-to-back with in_valid held high.
    do_op(8'h81, 8'h7F, 1, 0);
    do_op(8'h33, 8'hCD, 1, 1);
    do_op(8'hE0, 8'h40, 0, 1);
    drain();

    rand_or = 1'b1;
    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), 0, 0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_or = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
